edge_generator: RTL and testbench

- Transmit-side counterpart of the edge detector: converts edge requests into a driven level signal `sig_out`.
- Requests arrive on a valid/ready handshake. Every emitted edge is marked by one-cycle strobes aligned with the level change.
- An edge detector watching `sig_out` must report exactly the edges this block strobes, so the pair can be used in loopback.
- Each new level is held for a programmable minimum time before the next request is accepted.

---
 rtl/edge_generator_if.sv | 28 ++
 rtl/edge_generator.sv | 140 ++++++++++++++
 tb/tb_edge_generator.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/edge_generator_if.sv
// Request/level bundle for edge_generator.
//   master (requester): drives req_valid, req_type, req_hold; observes the rest.
//   slave  (generator): drives req_ready, sig_out, edge_rise, edge_fall,
//                       edge_either, err_noop, busy.
interface edge_generator_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_type;
  logic [CNT_W-1:0] req_hold;
  logic             sig_out;
  logic             edge_rise;
  logic             edge_fall;
  logic             edge_either;
  logic             err_noop;
  logic             busy;

  modport master (
    output req_valid, req_type, req_hold,
    input  req_ready, sig_out, edge_rise, edge_fall, edge_either, err_noop, busy
  );

  modport slave (
    input  req_valid, req_type, req_hold,
    output req_ready, sig_out, edge_rise, edge_fall, edge_either, err_noop, busy
  );
endinterface

// File: rtl/edge_generator.sv
// edge_generator: turns rise/fall/toggle/pulse requests into a registered
// level on sig_out, with one-cycle strobes aligned to each level change.
// Each new level is held for H = max(req_hold,1) cycles before the next
// request is accepted; a pulse holds the inverted level H cycles, restores
// it and spends one more cycle before returning to idle.
// Ports:
//   clk    - clock, posedge
//   reset  - asynchronous, active-high
//   bus    - edge_generator_if.slave (request handshake, level and strobes)
module edge_generator #(
  parameter int unsigned CNT_W      = 8,
  parameter bit          INIT_LEVEL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  edge_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PULSE_ON,
    PULSE_RESTORE
  } state_e;

  localparam logic [1:0] REQ_RISE   = 2'b00;
  localparam logic [1:0] REQ_FALL   = 2'b01;
  localparam logic [1:0] REQ_TOGGLE = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sig_q, sig_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             noop_q, noop_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_m1;

  // H-1 with a zero request treated as H=1
  assign hold_m1 = (bus.req_hold == '0) ? '0 : bus.req_hold - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    noop_d  = 1'b0;
    ready_d = ready_q;

    unique case (state_q)
      IDLE: begin
        // ready_q is 0 only in the first cycle after reset release
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          unique case (bus.req_type)
            REQ_RISE, REQ_FALL: begin
              if (sig_q == (bus.req_type == REQ_RISE)) begin
                noop_d = 1'b1;
              end else begin
                sig_d   = ~sig_q;
                cnt_d   = hold_m1;
                state_d = HOLD;
                ready_d = 1'b0;
              end
            end
            REQ_TOGGLE: begin
              sig_d   = ~sig_q;
              cnt_d   = hold_m1;
              state_d = HOLD;
              ready_d = 1'b0;
            end
            default: begin
              sig_d   = ~sig_q;
              cnt_d   = hold_m1;
              state_d = PULSE_ON;
              ready_d = 1'b0;
            end
          endcase
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE_ON: begin
        if (cnt_q == '0) begin
          sig_d   = ~sig_q;
          state_d = PULSE_RESTORE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

    // strobes derive from the level change itself, so they can never
    // disagree with what a detector on sig_out would see
    rise_d = sig_d & ~sig_q;
    fall_d = ~sig_d & sig_q;
    busy_d = ~ready_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      noop_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      noop_q  <= noop_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.sig_out     = sig_q;
  assign bus.edge_rise   = rise_q;
  assign bus.edge_fall   = fall_q;
  assign bus.edge_either = rise_q | fall_q;
  assign bus.err_noop    = noop_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_edge_generator.sv
// Directed bench for edge_generator plus a randomized loopback run against
// a behavioural edge detector watching sig_out.
module tb_edge_generator;

  localparam int unsigned CNT_W = 8;

  logic clk;
  logic reset;

  edge_generator_if #(.CNT_W(CNT_W)) bus ();

  edge_generator #(
    .CNT_W      (CNT_W),
    .INIT_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [CNT_W-1:0] h);
    bus.req_valid = v;
    bus.req_type  = t;
    bus.req_hold  = h;
  endtask

  // loopback monitor: detector model plus generator strobe tallies
  logic lb_en = 1'b0;
  logic prev_sig = 1'b0;
  int   det_r = 0, det_f = 0, gen_r = 0, gen_f = 0, gen_e = 0, gen_n = 0, overlap = 0;

  always @(negedge clk) begin
    prev_sig <= bus.sig_out;
    if (lb_en) begin
      if (bus.sig_out && !prev_sig) det_r <= det_r + 1;
      if (!bus.sig_out && prev_sig) det_f <= det_f + 1;
      if (bus.edge_rise)   gen_r <= gen_r + 1;
      if (bus.edge_fall)   gen_f <= gen_f + 1;
      if (bus.edge_either) gen_e <= gen_e + 1;
      if (bus.err_noop)    gen_n <= gen_n + 1;
      if ((bus.err_noop && bus.edge_either) || (bus.edge_rise && bus.edge_fall))
        overlap <= overlap + 1;
    end
  end

  initial begin
    int low_cnt;
    int strobe_cnt;
    logic lvl;
    int exp_noop;
    int exp_edges;

    reset = 1'b1;
    drive(1'b0, 2'b00, '0);

    // reset state
    repeat (3) tick();
    check("rst_sig",    bus.sig_out,     0);
    check("rst_ready",  bus.req_ready,   0);
    check("rst_busy",   bus.busy,        0);
    check("rst_either", bus.edge_either, 0);
    check("rst_noop",   bus.err_noop,    0);
    reset = 1'b0;
    check("rel_ready0", bus.req_ready, 0);
    tick();
    check("rel_ready1", bus.req_ready,   1);
    check("rel_busy",   bus.busy,        0);
    check("rel_sig",    bus.sig_out,     0);
    check("rel_either", bus.edge_either, 0);

    // rise with H=3
    drive(1'b1, 2'b00, 8'd3);
    tick();
    drive(1'b0, 2'b00, '0);
    check("rise_sig",    bus.sig_out,     1);
    check("rise_rise",   bus.edge_rise,   1);
    check("rise_fall",   bus.edge_fall,   0);
    check("rise_either", bus.edge_either, 1);
    check("rise_busy",   bus.busy,        1);
    low_cnt = 0;
    for (int c = 0; c < 20 && !bus.req_ready; c++) begin
      low_cnt++;
      tick();
      if (c == 0) check("rise_strobe_1cyc", bus.edge_rise, 0);
    end
    check("rise_ready_low_cycles", low_cnt, 3);

    // redundant rise -> noop
    drive(1'b1, 2'b00, 8'd3);
    tick();
    drive(1'b0, 2'b00, '0);
    check("noop_flag",   bus.err_noop,    1);
    check("noop_either", bus.edge_either, 0);
    check("noop_sig",    bus.sig_out,     1);
    check("noop_ready",  bus.req_ready,   1);
    tick();
    check("noop_clear",  bus.err_noop,    0);

    // toggle stream, H=0, valid held high; starting level 1
    drive(1'b1, 2'b10, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("tgl_sig%0d", i),  bus.sig_out,   ((i / 2) % 2 == 0) ? 0 : 1);
      check($sformatf("tgl_rise%0d", i), bus.edge_rise, (i % 4 == 2) ? 1 : 0);
      check($sformatf("tgl_fall%0d", i), bus.edge_fall, (i % 4 == 0) ? 1 : 0);
    end
    drive(1'b0, 2'b00, '0);

    // fall back to 0
    drive(1'b1, 2'b01, 8'd0);
    tick();
    drive(1'b0, 2'b00, '0);
    check("fall_sig",  bus.sig_out,   0);
    check("fall_fall", bus.edge_fall, 1);
    tick();
    check("fall_ready", bus.req_ready, 1);

    // pulse H=4 from 0
    drive(1'b1, 2'b11, 8'd4);
    tick();
    drive(1'b0, 2'b00, '0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pls_sig%0d", i),  bus.sig_out,   (i < 4) ? 1 : 0);
      check($sformatf("pls_busy%0d", i), bus.busy,      (i < 5) ? 1 : 0);
      check($sformatf("pls_rise%0d", i), bus.edge_rise, (i == 0) ? 1 : 0);
      check($sformatf("pls_fall%0d", i), bus.edge_fall, (i == 4) ? 1 : 0);
      tick();
    end

    // reset during the 2nd cycle of a pulse with H=5
    drive(1'b1, 2'b11, 8'd5);
    tick();
    drive(1'b0, 2'b00, '0);
    check("prst_rise", bus.edge_rise, 1);
    tick();
    reset = 1'b1;
    #1;
    check("prst_sig",    bus.sig_out,     0);
    check("prst_ready",  bus.req_ready,   0);
    check("prst_busy",   bus.busy,        0);
    check("prst_either", bus.edge_either, 0);
    tick();
    tick();
    reset = 1'b0;
    check("prst_rel_ready0", bus.req_ready, 0);
    strobe_cnt = 0;
    tick();
    check("prst_rel_ready1", bus.req_ready, 1);
    check("prst_rel_sig",    bus.sig_out,   0);
    for (int c = 0; c < 8; c++) begin
      if (bus.edge_either || bus.sig_out) strobe_cnt++;
      tick();
    end
    check("prst_no_restore", strobe_cnt, 0);

    // loopback with random requests
    lvl       = 1'b0;
    exp_noop  = 0;
    exp_edges = 0;
    lb_en     = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [1:0] typ;
      logic acc;
      typ = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
      drive(1'b1, typ, 8'($urandom_range(0, 3)));
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        if (bus.req_ready) acc = 1'b1;
        tick();
      end
      drive(1'b0, 2'b00, '0);
      if (!acc) check("lb_accept_timeout", 0, 1);
      case (typ)
        2'b00: if (lvl) exp_noop++; else begin lvl = 1'b1; exp_edges++; end
        2'b01: if (!lvl) exp_noop++; else begin lvl = 1'b0; exp_edges++; end
        2'b10: begin lvl = ~lvl; exp_edges++; end
        default: exp_edges += 2;
      endcase
    end
    repeat (10) tick();
    lb_en = 1'b0;
    @(negedge clk);
    #1;
    check("lb_det_rise",  det_r,         gen_r);
    check("lb_det_fall",  det_f,         gen_f);
    check("lb_edges",     gen_r + gen_f, exp_edges);
    check("lb_either",    gen_e,         exp_edges);
    check("lb_noop",      gen_n,         exp_noop);
    check("lb_overlap",   overlap,       0);
    check("lb_final_sig", bus.sig_out,   lvl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1);
  end

endmodule
